// File: rtl/cnu_sm_minfind.sv
// Purpose: LDPC CNU input front-end; converts serial two's-complement v2c messages to sign-magnitude
//   and accumulates per row: min1, min2, index of min1, sign parity, per-edge signs and beat count.
// Latency: row summary registered, out_valid one cycle after the closing beat is accepted.
// Backpressure: in_ready drops only while a summary is held (out_valid && !out_ready); accumulation stalls.
// Ports:
//   clk, rst          - clock, synchronous active-high reset
//   in_valid/in_ready - input beat handshake; in_data (IN_SIZE+1 bit signed), in_last closes the row
//   out_valid/ready   - row summary handshake
//   out_min1/min2     - two smallest magnitudes; out_idx = beat position of min1
//   out_par/out_sgns  - XOR of signs / per-beat signs; out_cnt = beats in row; out_ovf = closed by DEG_MAX
module cnu_sm_minfind #(
  parameter int IN_SIZE = 8,
  parameter int DEG_MAX = 16,
  parameter int IDX_W   = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [IN_SIZE:0]   in_data,
  input  logic               in_last,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [IN_SIZE-1:0] out_min1,
  output logic [IN_SIZE-1:0] out_min2,
  output logic [IDX_W-1:0]   out_idx,
  output logic               out_par,
  output logic [DEG_MAX-1:0] out_sgns,
  output logic [IDX_W:0]     out_cnt,
  output logic               out_ovf
);

  localparam logic [IDX_W:0] CNT_LAST = (IDX_W+1)'(DEG_MAX - 1);

  // Accumulator state; only cnt is meaningful between rows.
  logic [IN_SIZE-1:0] acc_min1, acc_min2;
  logic [IDX_W-1:0]   acc_idx;
  logic               acc_par;
  logic [DEG_MAX-1:0] acc_sgns;
  logic [IDX_W:0]     cnt;

  logic               sgn;
  logic               most_neg;
  logic [IN_SIZE-1:0] mag;
  logic               accept;
  logic               deg_full;
  logic               close;

  logic [IN_SIZE-1:0] nx_min1, nx_min2;
  logic [IDX_W-1:0]   nx_idx;
  logic               nx_par;
  logic [DEG_MAX-1:0] nx_sgns;

  assign in_ready = !(out_valid && !out_ready);
  assign accept   = in_valid && in_ready;
  assign deg_full = (cnt == CNT_LAST);
  assign close    = accept && (in_last || deg_full);

  // Negating only the low IN_SIZE bits gives the same truncated magnitude;
  // the most-negative code has no positive counterpart and saturates.
  always_comb begin
    sgn      = in_data[IN_SIZE];
    most_neg = (in_data == {1'b1, {IN_SIZE{1'b0}}});
    if (most_neg)
      mag = '1;
    else if (sgn)
      mag = -in_data[IN_SIZE-1:0];
    else
      mag = in_data[IN_SIZE-1:0];
  end

  // Post-update accumulator values for the beat being presented.
  always_comb begin
    nx_min1 = acc_min1;
    nx_min2 = acc_min2;
    nx_idx  = acc_idx;
    nx_par  = acc_par ^ sgn;
    nx_sgns = acc_sgns;
    if (cnt == '0) begin
      nx_min1 = mag;
      nx_min2 = '1;
      nx_idx  = '0;
      nx_par  = sgn;
      nx_sgns = '0;
      nx_sgns[0] = sgn;
    end else begin
      // Strict compares: ties keep the earlier beat as min1.
      if (mag < acc_min1) begin
        nx_min2 = acc_min1;
        nx_min1 = mag;
        nx_idx  = cnt[IDX_W-1:0];
      end else if (mag < acc_min2) begin
        nx_min2 = mag;
      end
      nx_sgns[cnt[IDX_W-1:0]] = sgn;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      acc_min1 <= nx_min1;
      acc_min2 <= nx_min2;
      acc_idx  <= nx_idx;
      acc_par  <= nx_par;
      acc_sgns <= nx_sgns;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt       <= '0;
      out_valid <= 1'b0;
      out_min1  <= '0;
      out_min2  <= '0;
      out_idx   <= '0;
      out_par   <= 1'b0;
      out_sgns  <= '0;
      out_cnt   <= '0;
      out_ovf   <= 1'b0;
    end else begin
      if (out_valid && out_ready)
        out_valid <= 1'b0;
      if (accept) begin
        if (close) begin
          cnt       <= '0;
          out_valid <= 1'b1;
          out_min1  <= nx_min1;
          out_min2  <= nx_min2;
          out_idx   <= nx_idx;
          out_par   <= nx_par;
          out_sgns  <= nx_sgns;
          out_cnt   <= cnt + 1'b1;
          out_ovf   <= deg_full;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_cnu_sm_minfind.sv
// Purpose: directed bench for cnu_sm_minfind; table of rows with hand-computed summaries,
//   plus sequences for backpressure hold, reset mid-row and reset with a pending summary.
// Timing: inputs driven 1 time unit after posedge, outputs sampled at the same point.
module tb_cnu_sm_minfind;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [8:0]  in_data;
  logic        in_last;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  out_min1;
  logic [7:0]  out_min2;
  logic [3:0]  out_idx;
  logic        out_par;
  logic [15:0] out_sgns;
  logic [4:0]  out_cnt;
  logic        out_ovf;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  cnu_sm_minfind dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_min1  (out_min1),
    .out_min2  (out_min2),
    .out_idx   (out_idx),
    .out_par   (out_par),
    .out_sgns  (out_sgns),
    .out_cnt   (out_cnt),
    .out_ovf   (out_ovf)
  );

  typedef struct {
    int              n;
    logic [15:0][8:0] d;
    logic            use_last;
    logic [7:0]      min1;
    logic [7:0]      min2;
    logic [3:0]      idx;
    logic            par;
    logic [15:0]     sgns;
    logic [4:0]      cnt;
    logic            ovf;
  } row_t;

  localparam int NROWS = 8;
  row_t rows [NROWS];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_summary(input string tag, input row_t r);
    check({tag, ".valid"}, 32'(out_valid), 32'(1'b1));
    check({tag, ".min1"},  32'(out_min1),  32'(r.min1));
    check({tag, ".min2"},  32'(out_min2),  32'(r.min2));
    check({tag, ".idx"},   32'(out_idx),   32'(r.idx));
    check({tag, ".par"},   32'(out_par),   32'(r.par));
    check({tag, ".sgns"},  32'(out_sgns),  32'(r.sgns));
    check({tag, ".cnt"},   32'(out_cnt),   32'(r.cnt));
    check({tag, ".ovf"},   32'(out_ovf),   32'(r.ovf));
  endtask

  // Presents one beat for exactly one clock; returns at posedge+1.
  task automatic drive(input logic [8:0] d, input logic last);
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic init_rows();
    for (int r = 0; r < NROWS; r++) begin
      rows[r].d = '0;
      rows[r].use_last = 1'b1;
      rows[r].ovf = 1'b0;
    end
    // {+5,-3,+7,-3}
    rows[0].n = 4;
    rows[0].d[0] = 9'h005; rows[0].d[1] = 9'h1FD; rows[0].d[2] = 9'h007; rows[0].d[3] = 9'h1FD;
    rows[0].min1 = 8'd3; rows[0].min2 = 8'd3; rows[0].idx = 4'd1; rows[0].par = 1'b0;
    rows[0].sgns = 16'h000A; rows[0].cnt = 5'd4;
    // {-256, +255}: most-negative saturates to 255, tie keeps beat 0
    rows[1].n = 2;
    rows[1].d[0] = 9'h100; rows[1].d[1] = 9'h0FF;
    rows[1].min1 = 8'd255; rows[1].min2 = 8'd255; rows[1].idx = 4'd0; rows[1].par = 1'b1;
    rows[1].sgns = 16'h0001; rows[1].cnt = 5'd2;
    // {-1} degree-1
    rows[2].n = 1;
    rows[2].d[0] = 9'h1FF;
    rows[2].min1 = 8'd1; rows[2].min2 = 8'd255; rows[2].idx = 4'd0; rows[2].par = 1'b1;
    rows[2].sgns = 16'h0001; rows[2].cnt = 5'd1;
    // {0, +2} back-to-back
    rows[3].n = 2;
    rows[3].d[0] = 9'h000; rows[3].d[1] = 9'h002;
    rows[3].min1 = 8'd0; rows[3].min2 = 8'd2; rows[3].idx = 4'd0; rows[3].par = 1'b0;
    rows[3].sgns = 16'h0000; rows[3].cnt = 5'd2;
    // 16 x +9, never in_last -> closed by degree limit
    rows[4].n = 16; rows[4].use_last = 1'b0;
    for (int b = 0; b < 16; b++) rows[4].d[b] = 9'h009;
    rows[4].min1 = 8'd9; rows[4].min2 = 8'd9; rows[4].idx = 4'd0; rows[4].par = 1'b0;
    rows[4].sgns = 16'h0000; rows[4].cnt = 5'd16; rows[4].ovf = 1'b1;
    // {+10,+20,-4,+4,-2}
    rows[5].n = 5;
    rows[5].d[0] = 9'h00A; rows[5].d[1] = 9'h014; rows[5].d[2] = 9'h1FC;
    rows[5].d[3] = 9'h004; rows[5].d[4] = 9'h1FE;
    rows[5].min1 = 8'd2; rows[5].min2 = 8'd4; rows[5].idx = 4'd4; rows[5].par = 1'b0;
    rows[5].sgns = 16'h0014; rows[5].cnt = 5'd5;
    // 16 descending beats 16..1 with in_last on the final beat: ovf still set
    rows[6].n = 16;
    for (int b = 0; b < 16; b++) rows[6].d[b] = 9'(16 - b);
    rows[6].min1 = 8'd1; rows[6].min2 = 8'd2; rows[6].idx = 4'd15; rows[6].par = 1'b0;
    rows[6].sgns = 16'h0000; rows[6].cnt = 5'd16; rows[6].ovf = 1'b1;
    // {-128, +127}
    rows[7].n = 2;
    rows[7].d[0] = 9'h180; rows[7].d[1] = 9'h07F;
    rows[7].min1 = 8'd127; rows[7].min2 = 8'd128; rows[7].idx = 4'd1; rows[7].par = 1'b1;
    rows[7].sgns = 16'h0001; rows[7].cnt = 5'd2;
  endtask

  row_t tmp;

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    in_last   = 1'b0;
    out_ready = 1'b1;
    init_rows();

    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("rst.valid",    32'(out_valid), 32'd0);
    check("rst.in_ready", 32'(in_ready),  32'd1);
    check("rst.min1",     32'(out_min1),  32'd0);
    check("rst.min2",     32'(out_min2),  32'd0);
    check("rst.sgns",     32'(out_sgns),  32'd0);
    check("rst.cnt",      32'(out_cnt),   32'd0);
    check("rst.ovf",      32'(out_ovf),   32'd0);

    // Table rows, applied back-to-back with no idle cycles.
    for (int r = 0; r < NROWS; r++) begin
      for (int b = 0; b < rows[r].n; b++) begin
        check($sformatf("row%0d.b%0d.in_ready", r, b), 32'(in_ready), 32'd1);
        drive(rows[r].d[b], rows[r].use_last && (b == rows[r].n - 1));
        if (b == rows[r].n - 1)
          check_summary($sformatf("row%0d", r), rows[r]);
        else
          check($sformatf("row%0d.b%0d.valid", r, b), 32'(out_valid), 32'd0);
      end
    end
    drive(9'h000, 1'b0);
    check("drain.valid", 32'(out_valid), 32'd0);
    drive(9'h003, 1'b1);  // close the dangling row {0,+3}
    check("drain.min2", 32'(out_min2), 32'd3);

    // Backpressure: row {+4,+1} held while out_ready=0.
    out_ready = 1'b0;
    @(posedge clk); #1;  // let the previous summary sit; it must not be consumed
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    drive(9'h004, 1'b0);
    drive(9'h001, 1'b1);
    tmp = rows[0];
    tmp.min1 = 8'd1; tmp.min2 = 8'd4; tmp.idx = 4'd1; tmp.par = 1'b0;
    tmp.sgns = 16'h0000; tmp.cnt = 5'd2; tmp.ovf = 1'b0;
    check_summary("hold0", tmp);
    in_valid = 1'b1;
    in_data  = 9'h007;
    in_last  = 1'b1;
    for (int c = 0; c < 5; c++) begin
      check($sformatf("hold.c%0d.in_ready", c), 32'(in_ready), 32'd0);
      check($sformatf("hold.c%0d.valid", c),    32'(out_valid), 32'd1);
      check($sformatf("hold.c%0d.min1", c),     32'(out_min1), 32'd1);
      check($sformatf("hold.c%0d.idx", c),      32'(out_idx),  32'd1);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    #1;
    check("release.in_ready", 32'(in_ready), 32'd1);
    check("release.min1",     32'(out_min1), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
    // The pending +7 beat was accepted on the release cycle and closed a new row.
    tmp.min1 = 8'd7; tmp.min2 = 8'd255; tmp.idx = 4'd0; tmp.par = 1'b0;
    tmp.sgns = 16'h0000; tmp.cnt = 5'd1; tmp.ovf = 1'b0;
    check_summary("resume", tmp);
    @(posedge clk); #1;
    check("resume.fall", 32'(out_valid), 32'd0);

    // Reset mid-row discards the partial row.
    drive(9'h1FE, 1'b0);
    drive(9'h001, 1'b0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("midrst.valid", 32'(out_valid), 32'd0);
    @(posedge clk); #1;
    check("midrst.valid2", 32'(out_valid), 32'd0);
    drive(9'h006, 1'b1);
    tmp.min1 = 8'd6; tmp.min2 = 8'd255; tmp.idx = 4'd0; tmp.par = 1'b0;
    tmp.sgns = 16'h0000; tmp.cnt = 5'd1; tmp.ovf = 1'b0;
    check_summary("postrst", tmp);

    // Reset while a summary is pending drops it.
    out_ready = 1'b0;
    drive(9'h1F0, 1'b1);
    check("pendrst.valid_before", 32'(out_valid), 32'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    out_ready = 1'b1;
    check("pendrst.valid", 32'(out_valid), 32'd0);
    check("pendrst.min1",  32'(out_min1),  32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
